// File: rtl/an_decoder_seq_if.sv
// Stream handshake bundle for the AN-code decoder: codeword in, decoded result out.
interface an_decoder_seq_if #(
  parameter int AN_W = 23,
  parameter int N_W  = 17,
  parameter int P_W  = $clog2(AN_W)
);
  logic            in_valid;
  logic            in_ready;
  logic [AN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [N_W-1:0]  out_data;
  logic            out_corr;
  logic            out_uncorr;
  logic [P_W-1:0]  out_pos;
  logic            out_sign;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_corr, out_uncorr, out_pos, out_sign
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_corr, out_uncorr, out_pos, out_sign
  );
endinterface

// File: rtl/an_decoder_seq.sv
// Sequential AN-code decoder: bit-serial residue, single-bit arithmetic error
// search and correction, then bit-serial restoring division by A.
//
// state   | meaning
// IDLE    | waiting for a codeword
// RESID   | X mod A, one bit per cycle, MSB first
// SEARCH  | look for +/-2^i congruent to the residue, ascending i
// CORRECT | apply the correction, detect out-of-range result
// DIVIDE  | quotient of Y by A, one bit per cycle
// DONE    | result held until the consumer takes it
module an_decoder_seq #(
  parameter int A    = 47,
  parameter int AN_W = 23,
  parameter int N_W  = 17,
  parameter int P_W  = $clog2(AN_W)
) (
  input logic             clk,
  input logic             rst,
  an_decoder_seq_if.slave bus
);

  localparam int R_W = $clog2(A) + 1;
  localparam int C_W = $clog2(AN_W + 1);
  localparam logic [R_W-1:0] A_R      = R_W'(A);
  localparam logic [C_W-1:0] CNT_LAST = C_W'(AN_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESID, S_SEARCH, S_CORRECT, S_DIVIDE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AN_W-1:0] x_q, x_d;
  logic [R_W-1:0]  r_q, r_d;
  logic [R_W-1:0]  p_q, p_d;
  logic [C_W-1:0]  cnt_q, cnt_d;
  logic [P_W-1:0]  i_q, i_d;
  logic            found_q, found_d;
  logic            nomatch_q, nomatch_d;
  logic            sgn_q, sgn_d;
  logic [N_W-1:0]  data_q, data_d;
  logic            corr_q, corr_d;
  logic            uncorr_q, uncorr_d;
  logic [P_W-1:0]  pos_q, pos_d;
  logic            sign_q, sign_d;

  logic            in_ready;
  logic            accept;
  logic [R_W-1:0]  t_sh;
  logic            t_ge;
  logic [R_W-1:0]  t_red;
  logic [R_W-1:0]  p_dbl;
  logic [R_W-1:0]  p_nxt;
  logic [AN_W:0]   pow;
  logic [AN_W:0]   y;
  logic [AN_W-1:0] quot;

  assign in_ready = (state_q == S_IDLE) & ~rst;
  assign accept   = bus.in_valid & in_ready;

  // Shared shift/compare/subtract step for both the residue and the division.
  assign t_sh  = {r_q[R_W-2:0], x_q[AN_W-1]};
  assign t_ge  = (t_sh >= A_R);
  assign t_red = t_ge ? (t_sh - A_R) : t_sh;
  assign quot  = {x_q[AN_W-2:0], t_ge};

  assign p_dbl = {p_q[R_W-2:0], 1'b0};
  assign p_nxt = (p_dbl >= A_R) ? (p_dbl - A_R) : p_dbl;

  assign pow = {{AN_W{1'b0}}, 1'b1} << i_q;
  assign y   = sgn_q ? ({1'b0, x_q} + pow) : ({1'b0, x_q} - pow);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    r_d       = r_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    i_d       = i_q;
    found_d   = found_q;
    nomatch_d = nomatch_q;
    sgn_d     = sgn_q;
    data_d    = data_q;
    corr_d    = corr_q;
    uncorr_d  = uncorr_q;
    pos_d     = pos_q;
    sign_d    = sign_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d      = bus.in_data;
          r_d      = '0;
          cnt_d    = CNT_LAST;
          data_d   = '0;
          corr_d   = 1'b0;
          uncorr_d = 1'b0;
          pos_d    = '0;
          sign_d   = 1'b0;
          state_d  = S_RESID;
        end
      end
      S_RESID: begin
        // Rotating leaves x_q holding the original X after AN_W steps.
        r_d   = t_red;
        x_d   = {x_q[AN_W-2:0], x_q[AN_W-1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d     = CNT_LAST;
          i_d       = '0;
          p_d       = R_W'(1);
          found_d   = 1'b0;
          nomatch_d = 1'b0;
          sgn_d     = 1'b0;
          state_d   = (t_red == '0) ? S_CORRECT : S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (p_q == r_q) begin
          found_d = 1'b1;
          sgn_d   = 1'b0;
          state_d = S_CORRECT;
        end else if ((A_R - p_q) == r_q) begin
          found_d = 1'b1;
          sgn_d   = 1'b1;
          state_d = S_CORRECT;
        end else if (cnt_q == '0) begin
          nomatch_d = 1'b1;
          state_d   = S_CORRECT;
        end else begin
          i_d   = i_q + P_W'(1);
          p_d   = p_nxt;
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CORRECT: begin
        r_d     = '0;
        cnt_d   = CNT_LAST;
        state_d = S_DIVIDE;
        if (found_q) begin
          if (y[AN_W]) begin
            uncorr_d = 1'b1;
          end else begin
            x_d    = y[AN_W-1:0];
            corr_d = 1'b1;
            pos_d  = i_q;
            sign_d = sgn_q;
          end
        end else if (nomatch_q) begin
          uncorr_d = 1'b1;
        end
      end
      S_DIVIDE: begin
        r_d   = t_red;
        x_d   = quot;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          data_d  = quot[N_W-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      r_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      i_q       <= '0;
      found_q   <= 1'b0;
      nomatch_q <= 1'b0;
      sgn_q     <= 1'b0;
      data_q    <= '0;
      corr_q    <= 1'b0;
      uncorr_q  <= 1'b0;
      pos_q     <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      r_q       <= r_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      i_q       <= i_d;
      found_q   <= found_d;
      nomatch_q <= nomatch_d;
      sgn_q     <= sgn_d;
      data_q    <= data_d;
      corr_q    <= corr_d;
      uncorr_q  <= uncorr_d;
      pos_q     <= pos_d;
      sign_q    <= sign_d;
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == S_DONE) & ~rst;
  assign bus.out_data   = rst ? '0 : data_q;
  assign bus.out_corr   = corr_q & ~rst;
  assign bus.out_uncorr = uncorr_q & ~rst;
  assign bus.out_pos    = rst ? '0 : pos_q;
  assign bus.out_sign   = sign_q & ~rst;

endmodule

// File: tb/tb_an_decoder_seq.sv
// Directed bench for an_decoder_seq: default configuration plus a small
// A=31 / AN_W=10 instance for the uncorrectable case.
module tb_an_decoder_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  an_decoder_seq_if #(.AN_W(23), .N_W(17), .P_W(5)) b0 ();
  an_decoder_seq_if #(.AN_W(10), .N_W(5),  .P_W(4)) b1 ();

  an_decoder_seq #(.A(47), .AN_W(23), .N_W(17), .P_W(5)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  an_decoder_seq #(.A(31), .AN_W(10), .N_W(5), .P_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send0(input string tag, input logic [22:0] x);
    int t = 0;
    while (b0.in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_in_ready"}, 32'(b0.in_ready), 1);
    b0.in_valid = 1'b1;
    b0.in_data  = x;
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.in_data  = '0;
  endtask

  task automatic wait_valid0(output int lat);
    lat = 1;
    while (b0.out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check0(input string tag, input int lat, input int e_lat, input int e_data,
                        input int e_corr, input int e_uncorr, input int e_pos, input int e_sign);
    chk({tag, "_lat"},    lat, e_lat);
    chk({tag, "_data"},   32'(b0.out_data), e_data);
    chk({tag, "_corr"},   32'(b0.out_corr), e_corr);
    chk({tag, "_uncorr"}, 32'(b0.out_uncorr), e_uncorr);
    chk({tag, "_pos"},    32'(b0.out_pos), e_pos);
    chk({tag, "_sign"},   32'(b0.out_sign), e_sign);
  endtask

  task automatic release0(input string tag);
    b0.out_ready = 1'b1;
    @(negedge clk);
    b0.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(b0.out_valid), 0);
    chk({tag, "_ready_back"}, 32'(b0.in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;

    // Reset values while rst is held
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(b0.in_ready), 0);
    chk("rst_out_valid", 32'(b0.out_valid), 0);
    chk("rst_out_data",  32'(b0.out_data), 0);
    chk("rst_corr",      32'(b0.out_corr), 0);
    chk("rst_uncorr",    32'(b0.out_uncorr), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(b0.in_ready), 1);

    // Clean codeword
    send0("clean", 23'd47000);
    wait_valid0(lat);
    check0("clean", lat, 48, 1000, 0, 0, 0, 0);
    release0("clean");

    // +2^3 error
    send0("plus8", 23'd47008);
    wait_valid0(lat);
    check0("plus8", lat, 52, 1000, 1, 0, 3, 0);
    release0("plus8");

    // -2^4 error, with out_ready held high before out_valid
    b0.out_ready = 1'b1;
    send0("minus16", 23'd46984);
    wait_valid0(lat);
    check0("minus16", lat, 53, 1000, 1, 0, 4, 1);
    @(negedge clk);
    b0.out_ready = 1'b0;
    chk("minus16_consumed", 32'(b0.out_valid), 0);

    // Largest codeword, quotient truncated to N_W bits (178481 -> 47409)
    send0("max", 23'h7FFFFF);
    wait_valid0(lat);
    check0("max", lat, 48, 47409, 0, 0, 0, 0);
    release0("max");

    // -2^0 error next to the top of the range
    send0("maxm1", 23'h7FFFFE);
    wait_valid0(lat);
    check0("maxm1", lat, 49, 47409, 1, 0, 0, 1);
    release0("maxm1");

    // Residue 7 matches +2^12 first; subtract would underflow -> uncorrectable
    send0("under", 23'd7);
    wait_valid0(lat);
    chk("under_lat",    lat, 61);
    chk("under_data",   32'(b0.out_data), 0);
    chk("under_corr",   32'(b0.out_corr), 0);
    chk("under_uncorr", 32'(b0.out_uncorr), 1);
    release0("under");

    // Back-pressure: hold results for 5 cycles, in_valid must be ignored
    send0("stall", 23'd47000);
    wait_valid0(lat);
    chk("stall_lat", lat, 48);
    for (int k = 0; k < 5; k++) begin
      b0.in_valid = 1'b1;
      b0.in_data  = 23'd235;
      chk("stall_valid",    32'(b0.out_valid), 1);
      chk("stall_data",     32'(b0.out_data), 1000);
      chk("stall_in_ready", 32'(b0.in_ready), 0);
      @(negedge clk);
    end
    b0.in_valid = 1'b0;
    b0.in_data  = '0;
    chk("stall_hold_data", 32'(b0.out_data), 1000);
    release0("stall");
    send0("after_stall", 23'd235);
    wait_valid0(lat);
    check0("after_stall", lat, 48, 5, 0, 0, 0, 0);
    release0("after_stall");

    // Reset pulse in the middle of DIVIDE
    send0("abort", 23'd47000);
    repeat (34) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rst_valid",    32'(b0.out_valid), 0);
    chk("abort_rst_in_ready", 32'(b0.in_ready), 0);
    chk("abort_rst_data",     32'(b0.out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 32'(b0.in_ready), 1);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (b0.out_valid === 1'b1) seen = 1;
      @(negedge clk);
    end
    chk("abort_no_valid", seen, 0);
    send0("one", 23'd47);
    wait_valid0(lat);
    check0("one", lat, 48, 1, 0, 0, 0, 0);
    release0("one");

    // A=31, AN_W=10: residue 3 never matches +/-2^i -> uncorrectable
    seen = 0;
    while (b1.in_ready !== 1'b1 && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    chk("small_in_ready", 32'(b1.in_ready), 1);
    b1.in_valid = 1'b1;
    b1.in_data  = 10'd158;
    @(negedge clk);
    b1.in_valid = 1'b0;
    b1.in_data  = '0;
    lat = 1;
    while (b1.out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("small_lat",    lat, 32);
    chk("small_data",   32'(b1.out_data), 5);
    chk("small_corr",   32'(b1.out_corr), 0);
    chk("small_uncorr", 32'(b1.out_uncorr), 1);
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.out_ready = 1'b0;
    chk("small_done", 32'(b1.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
